branch_predictor: RTL

Parametrised dynamic branch predictor for the next-generation pipeline. It sits beside the IF stage and pairs a direct-mapped branch target buffer (BTB) with a pattern history table (PHT) of saturating counters, so IF can redirect to a predicted target in the fetch cycle instead of waiting for ID resolution and flush. Lookup is combinational from the fetch PC. Training is sequential, from the branch outcome the pipeline resolves later. It supports bimodal or gshare indexing and keeps performance counters.

---
 rtl/branch_predictor.sv | 119 +++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// branch_predictor
//   Dynamic branch predictor beside the IF stage: a direct-mapped BTB paired
//   with a PHT of saturating counters, bimodal or gshare indexed.
//   Lookup is combinational from the fetch PC. Training is sequential, from
//   the outcome the pipeline resolves later. Also keeps branch/mispredict
//   performance counters.
//
// Ports
//   clk, rst, clr   clock; synchronous active-high reset; clr has the same effect
//   lk_pc           fetch PC (word address)
//   pred_hit        BTB valid and tag match for lk_pc
//   pred_taken      pred_hit and PHT counter MSB set
//   pred_target     BTB target on hit, else 0
//   pred_idx        PHT index used; carried by the pipeline to resolution
//   upd_*           one resolved branch per cycle while upd_valid is high
//   perf_branches   saturating count of resolved branches
//   perf_mispred    saturating count of mispredicted branches
module branch_predictor #(
  parameter int unsigned BTB_ENTRIES = 16,
  parameter int unsigned PHT_ENTRIES = 64,
  parameter int unsigned CNT_W       = 2,
  parameter int unsigned ADDR_W      = 30,
  parameter int unsigned GSHARE      = 0,
  localparam int unsigned BTB_IDX_W  = $clog2(BTB_ENTRIES),
  localparam int unsigned PHT_IDX_W  = $clog2(PHT_ENTRIES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic [ADDR_W-1:0]    lk_pc,
  output logic                 pred_hit,
  output logic                 pred_taken,
  output logic [ADDR_W-1:0]    pred_target,
  output logic [PHT_IDX_W-1:0] pred_idx,
  input  logic                 upd_valid,
  input  logic [ADDR_W-1:0]    upd_pc,
  input  logic [PHT_IDX_W-1:0] upd_idx,
  input  logic                 upd_taken,
  input  logic [ADDR_W-1:0]    upd_target,
  input  logic                 upd_mispred,
  output logic [31:0]          perf_branches,
  output logic [31:0]          perf_mispred
);

  localparam int unsigned      TAG_W    = ADDR_W - BTB_IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  // Weakly not-taken; evaluates to 0 for a 1-bit counter.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);

  logic                 btb_valid_q [BTB_ENTRIES];
  logic [TAG_W-1:0]     btb_tag_q   [BTB_ENTRIES];
  logic [ADDR_W-1:0]    btb_tgt_q   [BTB_ENTRIES];
  logic [CNT_W-1:0]     pht_q       [PHT_ENTRIES];
  logic [PHT_IDX_W-1:0] ghr_q, ghr_d;
  logic [31:0]          perf_br_q, perf_br_d;
  logic [31:0]          perf_mp_q, perf_mp_d;
  logic [CNT_W-1:0]     cnt_cur, cnt_d;

  logic [BTB_IDX_W-1:0] lk_bidx, upd_bidx;
  logic [TAG_W-1:0]     lk_tag, upd_tag;

  assign lk_bidx  = lk_pc[BTB_IDX_W-1:0];
  assign lk_tag   = lk_pc[ADDR_W-1:BTB_IDX_W];
  assign upd_bidx = upd_pc[BTB_IDX_W-1:0];
  assign upd_tag  = upd_pc[ADDR_W-1:BTB_IDX_W];

  // Lookup reads only registered state, so a same-cycle update is not seen.
  assign pred_idx    = lk_pc[PHT_IDX_W-1:0] ^ ghr_q;
  assign pred_hit    = btb_valid_q[lk_bidx] && (btb_tag_q[lk_bidx] == lk_tag);
  assign pred_taken  = pred_hit && pht_q[pred_idx][CNT_W-1];
  assign pred_target = pred_hit ? btb_tgt_q[lk_bidx] : '0;

  assign perf_branches = perf_br_q;
  assign perf_mispred  = perf_mp_q;

  always_comb begin
    cnt_cur = pht_q[upd_idx];
    cnt_d   = cnt_cur;
    if (upd_taken) begin
      if (cnt_cur != CNT_MAX) cnt_d = cnt_cur + 1'b1;
    end else begin
      if (cnt_cur != '0) cnt_d = cnt_cur - 1'b1;
    end

    // Shift-then-or keeps this legal when the history is a single bit.
    ghr_d = '0;
    if (GSHARE != 0) ghr_d = (ghr_q << 1) | PHT_IDX_W'(upd_taken);

    perf_br_d = (perf_br_q == '1) ? perf_br_q : perf_br_q + 32'd1;
    perf_mp_d = (perf_mp_q == '1) ? perf_mp_q : perf_mp_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid_q[i] <= 1'b0;
        btb_tag_q[i]   <= '0;
        btb_tgt_q[i]   <= '0;
      end
      for (int unsigned i = 0; i < PHT_ENTRIES; i++) begin
        pht_q[i] <= CNT_INIT;
      end
      ghr_q     <= '0;
      perf_br_q <= '0;
      perf_mp_q <= '0;
    end else if (upd_valid) begin
      pht_q[upd_idx] <= cnt_d;
      if (upd_taken) begin
        btb_valid_q[upd_bidx] <= 1'b1;
        btb_tag_q[upd_bidx]   <= upd_tag;
        btb_tgt_q[upd_bidx]   <= upd_target;
      end
      ghr_q     <= ghr_d;
      perf_br_q <= perf_br_d;
      if (upd_mispred) perf_mp_q <= perf_mp_d;
    end
  end

endmodule
